// File: rtl/fft_pkg.sv
// Shared definitions for the streaming radix-2 SDF FFT stages.
package fft_pkg;

  localparam int TW_FRAC_DEF = 6;

  typedef enum logic {
    LOAD_DRAIN = 1'b0,
    BFLY       = 1'b1
  } half_e;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  // Reports whether x falls outside the signed range of a w-bit word.
  function automatic sat_e sat_chk(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return SAT_HI;
    if (x < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/cmul_sat.sv
// Combinational complex multiply by a fixed-point twiddle, arithmetic shift
// down by the twiddle fraction, then saturation to the output word.
module cmul_sat
  import fft_pkg::*;
#(
  parameter int DW_OUT  = 18,
  parameter int TW_W    = 8,
  parameter int TW_FRAC = TW_FRAC_DEF
) (
  input  logic signed [DW_OUT-1:0] b_r,
  input  logic signed [DW_OUT-1:0] b_i,
  input  logic signed [TW_W-1:0]   tw_r,
  input  logic signed [TW_W-1:0]   tw_i,
  output logic signed [DW_OUT-1:0] p_r,
  output logic signed [DW_OUT-1:0] p_i
);

  localparam int PW = DW_OUT + TW_W + 1;
  localparam logic signed [DW_OUT-1:0] MAX_V = {1'b0, {(DW_OUT-1){1'b1}}};
  localparam logic signed [DW_OUT-1:0] MIN_V = {1'b1, {(DW_OUT-1){1'b0}}};

  logic signed [PW-1:0] br_x, bi_x, twr_x, twi_x;
  logic signed [PW-1:0] pr_sh, pi_sh;
  sat_e sat_r, sat_i;

  always_comb begin
    br_x  = PW'(b_r);
    bi_x  = PW'(b_i);
    twr_x = PW'(tw_r);
    twi_x = PW'(tw_i);
    // PW holds the full-precision sum of two products without overflow.
    pr_sh = (br_x * twr_x - bi_x * twi_x) >>> TW_FRAC;
    pi_sh = (br_x * twi_x + bi_x * twr_x) >>> TW_FRAC;
    sat_r = sat_chk(64'(pr_sh), DW_OUT);
    sat_i = sat_chk(64'(pi_sh), DW_OUT);
    p_r = (sat_r == SAT_HI) ? MAX_V : (sat_r == SAT_LO) ? MIN_V : pr_sh[DW_OUT-1:0];
    p_i = (sat_i == SAT_HI) ? MAX_V : (sat_i == SAT_LO) ? MIN_V : pi_sh[DW_OUT-1:0];
  end

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage: delay line, frame counter,
// optional twiddle multiply on the drained differences, registered output.
module sdf_r2_stage
  import fft_pkg::*;
#(
  parameter int DW_IN   = 17,
  parameter int DW_OUT  = 18,
  parameter int DEPTH   = 16,
  parameter int TW_W    = 8,
  parameter int TW_FRAC = TW_FRAC_DEF,
  parameter int MUL_EN  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       flush,
  input  logic signed [DW_IN-1:0]    in_r,
  input  logic signed [DW_IN-1:0]    in_i,
  output logic [$clog2(DEPTH)-1:0]   tw_idx,
  input  logic signed [TW_W-1:0]     tw_r,
  input  logic signed [TW_W-1:0]     tw_i,
  output logic                       out_valid,
  output logic signed [DW_OUT-1:0]   out_r,
  output logic signed [DW_OUT-1:0]   out_i
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic pending_reg, pending_next;
  logic seen_reg, seen_next;
  logic signed [DW_OUT-1:0] dl_r_reg [DEPTH];
  logic signed [DW_OUT-1:0] dl_i_reg [DEPTH];

  logic adv, wrap, emit;
  half_e half;
  logic signed [DW_OUT-1:0] a_r, a_i, b_r, b_i;
  logic signed [DW_OUT-1:0] d_r, d_i, ent_r, ent_i, res_r, res_i;

  generate
    if (MUL_EN != 0) begin : g_mul
      cmul_sat #(
        .DW_OUT (DW_OUT),
        .TW_W   (TW_W),
        .TW_FRAC(TW_FRAC)
      ) u_cmul (
        .b_r (b_r),
        .b_i (b_i),
        .tw_r(tw_r),
        .tw_i(tw_i),
        .p_r (d_r),
        .p_i (d_i)
      );
    end else begin : g_bypass
      assign d_r = b_r;
      assign d_i = b_i;
    end
  endgenerate

  always_comb begin
    adv    = in_valid | flush;
    half   = half_e'(cnt_reg[CW-1]);
    wrap   = (cnt_reg == CW'(2 * DEPTH - 1));
    tw_idx = cnt_reg[IW-1:0];
    a_r    = in_valid ? DW_OUT'(in_r) : '0;
    a_i    = in_valid ? DW_OUT'(in_i) : '0;
    b_r    = dl_r_reg[DEPTH-1];
    b_i    = dl_i_reg[DEPTH-1];
    cnt_next = cnt_reg + CW'(1);
    // A frame made only of flush cycles leaves nothing to drain next time.
    seen_next    = wrap ? 1'b0 : (seen_reg | in_valid);
    pending_next = wrap ? (seen_reg | in_valid) : pending_reg;
    ent_r = a_r;
    ent_i = a_i;
    res_r = d_r;
    res_i = d_i;
    emit  = pending_reg;
    if (half == BFLY) begin
      res_r = b_r + a_r;
      res_i = b_i + a_i;
      ent_r = b_r - a_r;
      ent_i = b_i - a_i;
      emit  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      seen_reg    <= 1'b0;
      out_valid   <= 1'b0;
      out_r       <= '0;
      out_i       <= '0;
    end else begin
      out_valid <= adv & emit;
      if (adv) begin
        cnt_reg     <= cnt_next;
        pending_reg <= pending_next;
        seen_reg    <= seen_next;
        if (emit) begin
          out_r <= res_r;
          out_i <= res_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        dl_r_reg[k] <= '0;
        dl_i_reg[k] <= '0;
      end
    end else if (adv) begin
      dl_r_reg[0] <= ent_r;
      dl_i_reg[0] <= ent_i;
      for (int k = 1; k < DEPTH; k++) begin
        dl_r_reg[k] <= dl_r_reg[k-1];
        dl_i_reg[k] <= dl_i_reg[k-1];
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed bench for a DEPTH=4 SDF stage: drain values, twiddle indices,
// saturation, stalls, back-to-back frames, flush drain and mid-frame reset.
module tb_sdf_r2_stage;

  localparam int DW_IN  = 17;
  localparam int DW_OUT = 18;
  localparam int DEPTH  = 4;
  localparam int TW_W   = 8;

  logic clk = 1'b0;
  logic rst, in_valid, flush;
  logic signed [DW_IN-1:0] in_r, in_i;
  logic [1:0] tw_idx;
  logic signed [TW_W-1:0] tw_r, tw_i;
  logic out_valid;
  logic signed [DW_OUT-1:0] out_r, out_i;

  int errors = 0;
  int checks = 0;
  string scen = "init";

  always #5 clk = ~clk;

  sdf_r2_stage #(
    .DW_IN  (DW_IN),
    .DW_OUT (DW_OUT),
    .DEPTH  (DEPTH),
    .TW_W   (TW_W),
    .TW_FRAC(6),
    .MUL_EN (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .flush    (flush),
    .in_r     (in_r),
    .in_i     (in_i),
    .tw_idx   (tw_idx),
    .tw_r     (tw_r),
    .tw_i     (tw_i),
    .out_valid(out_valid),
    .out_r    (out_r),
    .out_i    (out_i)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s:%s got %0d expected %0d", scen, tag, obs, exp_v);
    end
  endtask

  // ev: -1 skip, 0/1 expected out_valid; eidx: -1 skip tw_idx check.
  task automatic step(input logic v, input logic f, input int xr, input int xi,
                      input int ev, input int er, input int ei, input int eidx);
    in_valid = v;
    flush    = f;
    in_r     = xr[DW_IN-1:0];
    in_i     = xi[DW_IN-1:0];
    if (eidx >= 0) check("tw_idx", tw_idx, eidx);
    @(posedge clk);
    #1;
    $display("%s v=%0b f=%0b in=(%0d,%0d) idx=%0d -> ov=%0b out=(%0d,%0d)",
             scen, v, f, xr, xi, eidx, out_valid, out_r, out_i);
    if (ev >= 0) check("out_valid", out_valid, ev);
    if (ev == 1) begin
      check("out_r", out_r, er);
      check("out_i", out_i, ei);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_i", out_i, 0);
    check("rst_tw_idx", tw_idx, 0);
  endtask

  // Frame x=0..7 (real only) followed by a DEPTH-cycle drain flush.
  task automatic frame_and_drain(input int dr, input int di);
    for (int k = 0; k < 4; k++) step(1, 0, k, 0, 0, 0, 0, k);
    for (int k = 4; k < 8; k++) step(1, 0, k, 0, 1, 2 * k - 4, 0, -1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1, dr, di, k);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    in_r = '0; in_i = '0; tw_r = '0; tw_i = '0;

    scen = "basic";
    do_reset();
    tw_r = 8'sd64; tw_i = 8'sd0;
    frame_and_drain(-4, 0);

    scen = "minus_j";
    do_reset();
    tw_r = 8'sd0; tw_i = -8'sd64;
    frame_and_drain(0, 4);

    scen = "sat_pos";
    do_reset();
    tw_r = 8'sd45; tw_i = -8'sd45;
    for (int k = 0; k < 4; k++) step(1, 0, 65535, 65535, 0, 0, 0, -1);
    for (int k = 0; k < 4; k++) step(1, 0, -65536, -65536, 1, -1, -1, -1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1, 131071, 0, k);

    scen = "sat_neg";
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 0, -65536, -65536, 0, 0, 0, -1);
    for (int k = 0; k < 4; k++) step(1, 0, 65535, 65535, 1, -1, -1, -1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1, -131072, 0, k);

    scen = "stall";
    do_reset();
    tw_r = 8'sd64; tw_i = 8'sd0;
    for (int k = 0; k < 3; k++) step(1, 0, k, 0, 0, 0, 0, k);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 3);
    step(1, 0, 3, 0, 0, 0, 0, 3);
    step(1, 0, 4, 0, 1, 4, 0, -1);
    step(1, 0, 5, 0, 1, 6, 0, -1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, -1);
    step(1, 0, 6, 0, 1, 8, 0, -1);
    step(1, 0, 7, 0, 1, 10, 0, -1);
    step(0, 1, 0, 0, 1, -4, 0, 0);
    step(0, 1, 0, 0, 1, -4, 0, 1);
    for (int k = 0; k < 2; k++) step(0, 0, 0, 0, 0, 0, 0, 2);
    check("hold_out_r", out_r, -4);
    step(0, 1, 0, 0, 1, -4, 0, 2);
    step(0, 1, 0, 0, 1, -4, 0, 3);

    scen = "b2b";
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 0, k, 0, 0, 0, 0, k);
    for (int k = 4; k < 8; k++) step(1, 0, k, 0, 1, 2 * k - 4, 0, -1);
    for (int k = 10; k < 14; k++) step(1, 0, k, 0, 1, -4, 0, k - 10);
    for (int k = 14; k < 18; k++) step(1, 0, k, 0, 1, 2 * k - 4, 0, -1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 1, -4, 0, k);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, -1, 0, 0, -1);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0, 0, 0, k);

    scen = "mid_rst";
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 0, k + 20, 5, 0, 0, 0, k);
    step(1, 0, 24, 5, 1, 44, 10, -1);
    step(1, 0, 25, 5, 1, 46, 10, -1);
    do_reset();
    frame_and_drain(-4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
